tehb_dataless_fifo: RTL and testbench

- Dataless elastic buffer that cuts the backward (ready) combinational path of a valid/ready channel.
- Complements the valid-cutting opaque buffer chain. It is transparent on the forward path and opaque on the backward path.
- Holds up to NUM_SLOTS tokens as an occupancy count. Used where a long ready path through a dataflow circuit must be broken without adding forward latency.

---
 rtl/tehb_dataless_fifo_pkg.sv | 14 +
 rtl/tehb_dataless_fifo.sv | 67 ++++++
 tb/tb_tehb_dataless_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tehb_dataless_fifo_pkg.sv
// Shared handshake helpers for the dataless elastic buffers.
package tehb_dataless_fifo_pkg;

  // Bits needed to hold the values 0..n (clog2(n+1), at least 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < (64'(n) + 64'd1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tehb_dataless_fifo.sv
// Dataless TEHB: cuts the ready path of a valid/ready channel while the
// forward (valid) path stays combinational. State is a token occupancy count.
module tehb_dataless_fifo
  import tehb_dataless_fifo_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CNT_W     = cnt_width(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  output logic             outs_valid,
  input  logic             outs_ready,
  output logic [CNT_W-1:0] occupancy
);

  if (NUM_SLOTS < 1) begin : g_bad_slots
    $error("tehb_dataless_fifo: NUM_SLOTS must be at least 1");
  end
  if (CNT_W != cnt_width(NUM_SLOTS)) begin : g_bad_cnt_w
    $error("tehb_dataless_fifo: CNT_W is derived from NUM_SLOTS and must not be overridden");
  end

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SLOTS);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             enq;
  logic             deq;

  // Handshake outputs; ready depends only on the registered count (and reset).
  always_comb begin
    ins_ready  = !rst && (count < FULL);
    outs_valid = !rst && (ins_valid || (count != '0));
    enq        = ins_valid && ins_ready;
    deq        = outs_valid && outs_ready;
  end

  // Next occupancy: +1 on enqueue only, -1 on dequeue only, else hold (covers bypass).
  always_comb begin
    count_next = count;
    if (enq && !deq) begin
      count_next = count + CNT_W'(1);
    end else if (!enq && deq) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Occupancy register; reset discards all stored tokens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign occupancy = count;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) count <= FULL);
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !((count == '0) && deq && !enq));
  a_valid_held : assert property (@(posedge clk) disable iff (rst)
    ((count != '0) && !deq) |=> outs_valid);

endmodule

// File: tb/tb_tehb_dataless_fifo.sv
// Scoreboard bench for tehb_dataless_fifo (NUM_SLOTS=4).
module tb_tehb_dataless_fifo;
  import tehb_dataless_fifo_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = cnt_width(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          ins_valid;
  logic          ins_ready;
  logic          outs_valid;
  logic          outs_ready;
  logic [CW-1:0] occupancy;

  typedef struct packed {
    logic ir;
    logic ov;
    logic [7:0] occ;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   enq_total = 0;
  int   deq_total = 0;

  tehb_dataless_fifo #(.NUM_SLOTS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: counts handshakes and checks outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ins_valid && ins_ready) enq_total++;
      if (outs_valid && outs_ready) deq_total++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ins_ready", int'(ins_ready), int'(e.ir));
        check("outs_valid", int'(outs_valid), int'(e.ov));
        check("occupancy", int'(occupancy), int'(e.occ));
      end
    end
  end

  // One cycle of stimulus driven just after the rising edge, plus its expectation.
  task automatic step(input logic r, input logic iv, input logic ordy,
                      input logic e_ir, input logic e_ov, input int e_occ);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    ins_valid  = iv;
    outs_ready = ordy;
    e.ir  = e_ir;
    e.ov  = e_ov;
    e.occ = 8'(e_occ);
    q.push_back(e);
  endtask

  initial begin
    int enq0;
    int deq0;
    int enq_rst;
    int deq_rst;
    int m;
    logic iv;
    logic ordy;
    logic e_ir;
    logic e_ov;
    exp_t e;

    rst        = 1'b1;
    ins_valid  = 1'b0;
    outs_ready = 1'b0;

    // Reset: handshake outputs forced low even with ins_valid high.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Test 1: release with continuous traffic, pure bypass for 100 cycles.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 1; i < 100; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    @(negedge clk); #1;
    check("bypass_enq", enq_total, 100);
    check("bypass_deq", deq_total, 100);
    enq0 = enq_total;

    // Test 2: fill with downstream stalled; saturates at 4.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    @(negedge clk); #1;
    check("fill_enq", enq_total - enq0, 4);

    // Test 3: full, deq frees a slot; ready returns a cycle later.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3);

    // Test 4: drain with no input.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // Test 5: fill to 4, then wiggle outs_ready within one cycle.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4);
    check("ready_cut_a", int'(ins_ready), 0);
    #1 outs_ready = 1'b0;
    check("ready_cut_b", int'(ins_ready), 0);
    #1 outs_ready = 1'b1;
    check("ready_cut_c", int'(ins_ready), 0);
    #1 outs_ready = 1'b0;
    check("ready_cut_d", int'(ins_ready), 0);
    // outs_ready ends low: no deq, count stays 4.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3);

    // Test 6: asynchronous reset mid-cycle with count=2.
    @(posedge clk); #1;
    ins_valid  = 1'b1;
    outs_ready = 1'b0;
    check("pre_rst_occ", int'(occupancy), 2);
    #1 rst = 1'b1;
    #1;
    check("rst_occ", int'(occupancy), 0);
    check("rst_ins_ready", int'(ins_ready), 0);
    check("rst_outs_valid", int'(outs_valid), 0);
    e.ir = 1'b0; e.ov = 1'b0; e.occ = 8'd0;
    q.push_back(e);
    enq_rst = enq_total;
    deq_rst = deq_total;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Random stress against a small occupancy model.
    m = 0;
    for (int i = 0; i < 300; i++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      if (i >= 150) ordy = ~ordy;
      e_ir = (m < int'(N));
      e_ov = iv || (m > 0);
      step(1'b0, iv, ordy, e_ir, e_ov, m);
      m = m + ((iv && e_ir) ? 1 : 0) - ((e_ov && ordy) ? 1 : 0);
    end
    step(1'b0, 1'b0, 1'b0, (m < int'(N)), (m > 0), m);
    @(negedge clk); #1;
    check("conservation", enq_total - enq_rst, (deq_total - deq_rst) + int'(occupancy));
    check("final_occ", int'(occupancy), m);

    repeat (2) @(negedge clk);
    if (q.size() != 0) check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
